// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Shared definitions for the rv32i core control path: sequencer state
// encoding, base-ISA major opcodes, PC-select codes and the reset value
// of the instruction register.
// No ports (package).
package rv32i_pkg;

  // Sequencer states; encodings fixed so waveforms match older dumps.
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } ctrl_state_t;

  // RV32I major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Next-PC source select.
  localparam logic [1:0] PC_SEL_SEQ = 2'b00;  // pc + 4
  localparam logic [1:0] PC_SEL_IMM = 2'b01;  // pc + imm (taken branch / jal)
  localparam logic [1:0] PC_SEL_ALU = 2'b10;  // ALU result (jalr)

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True for the nine major opcodes implemented by the core.
  function automatic logic is_legal_opcode(input logic [6:0] opc);
    logic ok;
    ok = 1'b0;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_JAL, OPC_OP,
      OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_req_hold.sv
// mem_req_hold
// Holds a memory request high from a one-cycle start pulse until the
// memory acknowledges it. An ack arriving while no request is
// outstanding has no effect.
// Ports:
//   clk   in  1  clock
//   rst   in  1  asynchronous active-high reset (drops req immediately)
//   start in  1  begin a request; req is high from the next cycle
//   ack   in  1  memory completion
//   req   out 1  registered request level
module mem_req_hold (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  output logic req
);

  logic req_r;

  // Request latch: set by start, cleared only by an ack that matches a live request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_r <= 1'b0;
    end else if (start) begin
      req_r <= 1'b1;
    end else if (ack && req_r) begin
      req_r <= 1'b0;
    end else begin
      req_r <= req_r;
    end
  end

  assign req = req_r;

endmodule

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm
// Multi-cycle control sequencer for the rv32i core: FETCH -> DECODE ->
// EXEC -> (MEM) -> WB. Owns the instruction register and the imem/dmem
// request handshakes, and turns the decoder's static controls into
// single-cycle rf_we / pc_en strobes in WB.
// Optional feature: define RV32I_CTRL_TRAP_EN to halt in S_TRAP on an
// unimplemented opcode; otherwise such instructions retire as NOPs and
// trap is tied low.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req/ack/rdata       instruction fetch handshake and data
//   dmem_req/we/ack          data access handshake (we: 1 = store)
//   instr_q                  instruction register (to decoder)
//   dec_*                    decoder static controls
//   branch_taken             ALU compare result for current branch
//   rf_we, pc_en             one-cycle WB strobes
//   pc_sel                   next-PC source, meaningful while pc_en
//   instret                  retired-instruction count (wraps)
//   trap                     illegal-instruction halt
import rv32i_pkg::*;

module core_ctrl_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ack,
  output logic [31:0]          instr_q,
  input  logic                 dec_memRead,
  input  logic                 dec_memWrite,
  input  logic                 dec_regWrite,
  input  logic                 dec_jump,
  input  logic                 dec_branch,
  input  logic                 branch_taken,
  output logic                 rf_we,
  output logic                 pc_en,
  output logic [1:0]           pc_sel,
  output logic [INSTRET_W-1:0] instret,
  output logic                 trap
);

  ctrl_state_t          state_r;
  ctrl_state_t          state_next_s;
  logic [31:0]          instr_r;
  logic [INSTRET_W-1:0] instret_r;
  logic                 rf_we_r;
  logic                 pc_en_r;
  logic                 dmem_we_r;
  logic [6:0]           opcode_s;
  logic                 legal_s;
  logic                 mem_op_s;
  logic                 imem_done_s;
  logic                 dmem_done_s;
  logic                 imem_start_s;
  logic                 dmem_start_s;
  logic [1:0]           pc_sel_s;

  assign opcode_s = instr_r[6:0];
  assign legal_s  = is_legal_opcode(opcode_s);
  // Unknown opcodes never touch data memory, whatever the decoder says.
  assign mem_op_s = (dec_memRead || dec_memWrite) && legal_s;

  // Acks only count while the matching request is actually high.
  assign imem_done_s = imem_req && imem_ack;
  assign dmem_done_s = dmem_req && dmem_ack;

  // Requests are registered, so they are launched from the next-state
  // decode: the request is high for the whole first cycle of FETCH/MEM.
  assign imem_start_s = (state_next_s == S_FETCH) && !imem_req;
  assign dmem_start_s = (state_next_s == S_MEM) && !dmem_req;

  // Next-state decode for the instruction sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (imem_done_s) state_next_s = S_DECODE;
        else             state_next_s = S_FETCH;
      end
      S_DECODE: state_next_s = S_EXEC;
      S_EXEC: begin
`ifdef RV32I_CTRL_TRAP_EN
        if (!legal_s)      state_next_s = S_TRAP;
        else if (mem_op_s) state_next_s = S_MEM;
        else               state_next_s = S_WB;
`else
        if (mem_op_s) state_next_s = S_MEM;
        else          state_next_s = S_WB;
`endif
      end
      S_MEM: begin
        if (dmem_done_s) state_next_s = S_WB;
        else             state_next_s = S_MEM;
      end
      S_WB:    state_next_s = S_FETCH;
      S_TRAP:  state_next_s = S_TRAP;
      default: state_next_s = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= S_FETCH;
    else     state_r <= state_next_s;
  end

  // Instruction register: captured on the completing fetch only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  instr_r <= NOP_INSTR;
    else if (imem_done_s && state_r == S_FETCH) instr_r <= imem_rdata;
    else                                      instr_r <= instr_r;
  end

  // WB strobes, registered off the next state so they are high exactly
  // for the single WB cycle; decoder outputs are static by then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_en_r <= 1'b0;
      rf_we_r <= 1'b0;
    end else begin
      pc_en_r <= (state_next_s == S_WB);
      rf_we_r <= (state_next_s == S_WB) && dec_regWrite && legal_s;
    end
  end

  // Store/load direction, valid for exactly the life of dmem_req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               dmem_we_r <= 1'b0;
    else if (dmem_start_s) dmem_we_r <= dec_memWrite;
    else if (dmem_done_s)  dmem_we_r <= 1'b0;
    else                   dmem_we_r <= dmem_we_r;
  end

  // Retire on the edge that leaves WB, so a reset during WB loses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 instret_r <= '0;
    else if (state_r == S_WB) instret_r <= instret_r + INSTRET_W'(1);
    else                     instret_r <= instret_r;
  end

  // Next-PC select; unknown opcodes always fall through to pc+4.
  always_comb begin
    pc_sel_s = PC_SEL_SEQ;
    if (!legal_s)                                   pc_sel_s = PC_SEL_SEQ;
    else if (dec_jump && opcode_s == OPC_JALR)      pc_sel_s = PC_SEL_ALU;
    else if (opcode_s == OPC_JAL || (dec_branch && branch_taken))
                                                    pc_sel_s = PC_SEL_IMM;
    else                                            pc_sel_s = PC_SEL_SEQ;
  end

  mem_req_hold u_imem_req (
    .clk   (clk),
    .rst   (rst),
    .start (imem_start_s),
    .ack   (imem_ack),
    .req   (imem_req)
  );

  mem_req_hold u_dmem_req (
    .clk   (clk),
    .rst   (rst),
    .start (dmem_start_s),
    .ack   (dmem_ack),
    .req   (dmem_req)
  );

`ifdef RV32I_CTRL_TRAP_EN
  logic trap_r;

  // Trap flag: raised on entry to S_TRAP, held until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trap_r <= 1'b0;
    else     trap_r <= (state_next_s == S_TRAP);
  end

  assign trap = trap_r;
`else
  assign trap = 1'b0;
`endif

  assign instr_q = instr_r;
  assign dmem_we = dmem_we_r;
  assign rf_we   = rf_we_r;
  assign pc_en   = pc_en_r;
  assign pc_sel  = pc_sel_s;
  assign instret = instret_r;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb_core_ctrl_fsm
// Directed self-checking bench for core_ctrl_fsm. Uses a 3-bit retire
// counter so the wrap from all-ones to zero is reachable. Covers both
// builds (with and without RV32I_CTRL_TRAP_EN).
module tb_core_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic [31:0] instr_q;
  logic        dec_memRead;
  logic        dec_memWrite;
  logic        dec_regWrite;
  logic        dec_jump;
  logic        dec_branch;
  logic        branch_taken;
  logic        rf_we;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic [2:0]  instret;
  logic        trap;

  int vecs = 0;
  int errs = 0;

  core_ctrl_fsm #(.INSTRET_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .instr_q      (instr_q),
    .dec_memRead  (dec_memRead),
    .dec_memWrite (dec_memWrite),
    .dec_regWrite (dec_regWrite),
    .dec_jump     (dec_jump),
    .dec_branch   (dec_branch),
    .branch_taken (branch_taken),
    .rf_we        (rf_we),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .instret      (instret),
    .trap         (trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_dec();
    dec_memRead  = 1'b0;
    dec_memWrite = 1'b0;
    dec_regWrite = 1'b0;
    dec_jump     = 1'b0;
    dec_branch   = 1'b0;
    branch_taken = 1'b0;
  endtask

  // Called in a FETCH cycle; zero-wait fetch. Returns in the DECODE cycle.
  task automatic do_fetch(input logic [31:0] ins, input string tag);
    chk({tag, "_imem_req_fetch"}, {31'd0, imem_req}, 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = ins;
    cyc();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk({tag, "_instr_q"}, instr_q, ins);
    chk({tag, "_imem_req_decode"}, {31'd0, imem_req}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    dmem_ack   = 1'b0;
    clr_dec();
    repeat (2) cyc();

    // Reset state.
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_instr_q",  instr_q,           32'h0000_0013);
    chk("rst_instret",  {29'd0, instret},  32'd0);
    chk("rst_trap",     {31'd0, trap},     32'd0);
    chk("rst_rf_we",    {31'd0, rf_we},    32'd0);
    chk("rst_pc_en",    {31'd0, pc_en},    32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_dmem_we",  {31'd0, dmem_we},  32'd0);

    rst = 1'b0;
    cyc();
    chk("first_fetch_req", {31'd0, imem_req}, 32'd1);
    cyc();
    chk("fetch_req_hold", {31'd0, imem_req}, 32'd1);

    // Reset pulse while the fetch waits for its ack.
    rst = 1'b1;
    #1;
    chk("rst_async_drop", {31'd0, imem_req}, 32'd0);
    chk("rst_mid_pc_en",  {31'd0, pc_en},    32'd0);
    chk("rst_mid_rf_we",  {31'd0, rf_we},    32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    cyc();
    rst = 1'b0;
    chk("req_low_after_rst", {31'd0, imem_req}, 32'd0);
    cyc();
    chk("spurious_ack_ignored", instr_q, 32'h0000_0013);
    chk("fetch_restart", {31'd0, imem_req}, 32'd1);
    chk("rst_mid_instret", {29'd0, instret}, 32'd0);
    imem_ack = 1'b0;

    // addi x1,x0,5: 4-cycle zero-wait sequence.
    do_fetch(32'h0050_0093, "addi");
    dec_regWrite = 1'b1;
    cyc();
    chk("addi_exec_pc_en", {31'd0, pc_en}, 32'd0);
    cyc();
    chk("addi_wb_rf_we",  {31'd0, rf_we},  32'd1);
    chk("addi_wb_pc_en",  {31'd0, pc_en},  32'd1);
    chk("addi_wb_pc_sel", {30'd0, pc_sel}, 32'd0);
    cyc();
    chk("addi_instret",   {29'd0, instret}, 32'd1);
    chk("addi_post_rf_we", {31'd0, rf_we}, 32'd0);
    chk("addi_post_pc_en", {31'd0, pc_en}, 32'd0);
    clr_dec();

    // lw x2,0(x1) with dmem_ack three cycles late.
    do_fetch(32'h0000_A103, "lw");
    dec_memRead  = 1'b1;
    dec_regWrite = 1'b1;
    cyc();
    chk("lw_exec_dmem_req", {31'd0, dmem_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("lw_mem_dmem_req",  {31'd0, dmem_req}, 32'd1);
      chk("lw_mem_dmem_we",   {31'd0, dmem_we},  32'd0);
      chk("lw_mem_imem_req",  {31'd0, imem_req}, 32'd0);
      chk("lw_mem_pc_en",     {31'd0, pc_en},    32'd0);
      if (i == 3) dmem_ack = 1'b1;
    end
    cyc();
    dmem_ack = 1'b0;
    chk("lw_wb_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("lw_wb_rf_we",    {31'd0, rf_we},    32'd1);
    chk("lw_wb_pc_en",    {31'd0, pc_en},    32'd1);
    cyc();
    chk("lw_instret", {29'd0, instret}, 32'd2);
    clr_dec();

    // beq taken.
    do_fetch(32'h0020_8463, "beq_t");
    dec_branch   = 1'b1;
    branch_taken = 1'b1;
    cyc();
    cyc();
    chk("beq_t_pc_sel", {30'd0, pc_sel}, 32'd1);
    chk("beq_t_rf_we",  {31'd0, rf_we},  32'd0);
    chk("beq_t_pc_en",  {31'd0, pc_en},  32'd1);
    cyc();
    chk("beq_t_instret", {29'd0, instret}, 32'd3);
    clr_dec();

    // beq not taken.
    do_fetch(32'h0020_8463, "beq_nt");
    dec_branch   = 1'b1;
    branch_taken = 1'b0;
    cyc();
    cyc();
    chk("beq_nt_pc_sel", {30'd0, pc_sel}, 32'd0);
    chk("beq_nt_rf_we",  {31'd0, rf_we},  32'd0);
    cyc();
    chk("beq_nt_instret", {29'd0, instret}, 32'd4);
    clr_dec();

    // jalr x1,0(x2).
    do_fetch(32'h0001_00E7, "jalr");
    dec_jump     = 1'b1;
    dec_regWrite = 1'b1;
    cyc();
    cyc();
    chk("jalr_pc_sel", {30'd0, pc_sel}, 32'd2);
    chk("jalr_rf_we",  {31'd0, rf_we},  32'd1);
    cyc();
    clr_dec();

    // jal x1,8.
    do_fetch(32'h0080_00EF, "jal");
    dec_jump     = 1'b1;
    dec_regWrite = 1'b1;
    cyc();
    cyc();
    chk("jal_pc_sel", {30'd0, pc_sel}, 32'd1);
    chk("jal_rf_we",  {31'd0, rf_we},  32'd1);
    cyc();
    chk("jal_instret", {29'd0, instret}, 32'd6);
    clr_dec();

    // sw x2,4(x1), zero-wait: 5 cycles.
    do_fetch(32'h0020_A223, "sw");
    dec_memWrite = 1'b1;
    cyc();
    cyc();
    chk("sw_mem_dmem_req", {31'd0, dmem_req}, 32'd1);
    chk("sw_mem_dmem_we",  {31'd0, dmem_we},  32'd1);
    chk("sw_mem_imem_req", {31'd0, imem_req}, 32'd0);
    dmem_ack = 1'b1;
    cyc();
    dmem_ack = 1'b0;
    chk("sw_wb_rf_we",    {31'd0, rf_we},    32'd0);
    chk("sw_wb_pc_en",    {31'd0, pc_en},    32'd1);
    chk("sw_wb_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("sw_wb_dmem_we",  {31'd0, dmem_we},  32'd0);
    cyc();
    chk("sw_instret", {29'd0, instret}, 32'd7);
    clr_dec();

    // Opcode 7'b0000000 with deliberately noisy decoder outputs.
    do_fetch(32'h0000_0000, "ill");
    dec_regWrite = 1'b1;
    dec_branch   = 1'b1;
    branch_taken = 1'b1;
    cyc();
`ifdef RV32I_CTRL_TRAP_EN
    cyc();
    chk("ill_trap",     {31'd0, trap},     32'd1);
    chk("ill_pc_en",    {31'd0, pc_en},    32'd0);
    chk("ill_rf_we",    {31'd0, rf_we},    32'd0);
    chk("ill_imem_req", {31'd0, imem_req}, 32'd0);
    repeat (3) cyc();
    chk("ill_trap_hold",     {31'd0, trap},     32'd1);
    chk("ill_imem_req_hold", {31'd0, imem_req}, 32'd0);
    chk("ill_dmem_req_hold", {31'd0, dmem_req}, 32'd0);
    chk("ill_pc_en_hold",    {31'd0, pc_en},    32'd0);
    chk("ill_instret",       {29'd0, instret},  32'd7);
`else
    cyc();
    chk("ill_trap",   {31'd0, trap},   32'd0);
    chk("ill_rf_we",  {31'd0, rf_we},  32'd0);
    chk("ill_pc_en",  {31'd0, pc_en},  32'd1);
    chk("ill_pc_sel", {30'd0, pc_sel}, 32'd0);
    cyc();
    // 3-bit counter: 7 + 1 wraps to 0.
    chk("ill_instret_wrap", {29'd0, instret}, 32'd0);
    chk("ill_next_fetch",   {31'd0, imem_req}, 32'd1);
`endif
    clr_dec();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
